// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, serializer state encoding and header constant.
// FP16_SER_HDR_EN adds the HDR state that emits a header byte per word.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int BIAS   = 15;
    localparam int FP16_W = 1 + EXP_W + MAN_W;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYTE_A = 2'd1,
        S_BYTE_B = 2'd2
`ifdef FP16_SER_HDR_EN
        , S_HDR  = 2'd3
`endif
    } ser_state_e;

    // second=0 picks the byte sent first, second=1 the byte sent last
    function automatic logic [7:0] sel_byte(
        input logic [FP16_W-1:0] w,
        input logic              second,
        input logic              lsb_first
    );
        return (second ^ !lsb_first) ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count and full/empty flags.
// Uses synchronous active-low reset plus a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fp16_result_serializer.sv
// Buffers FP16 products and streams each as bytes on a valid/ready port.
// FP16_SER_HDR_EN prefixes every word with header byte 0xA5.
module fp16_result_serializer
    import fp16_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_byte,
    output logic          out_last,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    localparam logic LSBF = (LSB_FIRST != 0);

    ser_state_e        state_q;
    logic [FP16_W-1:0] hold_q;
    logic [7:0]        byte_q;
    logic              valid_q;
    logic              last_q;
    logic              ovf_q;

    logic              full, empty, push, pop;
    logic [FP16_W-1:0] rdata;
    logic [7:0]        first_byte;
    ser_state_e        first_state;

    assign in_ready  = !full;
    assign push      = in_valid && !full && !clear;
    assign out_valid = valid_q;
    assign out_byte  = byte_q;
    assign out_last  = last_q;
    assign overflow  = ovf_q;

    sync_fifo #(
        .WIDTH(FP16_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .push (push),
        .pop  (pop),
        .wdata(in_data),
        .rdata(rdata),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );

    always_comb begin
        pop = 1'b0;
        if (!clear) begin
            unique case (state_q)
                S_IDLE:   pop = !empty;
                S_BYTE_B: pop = out_ready && !empty;
                default:  pop = 1'b0;
            endcase
        end
    end

    // What the first beat of a freshly popped word looks like
    always_comb begin
`ifdef FP16_SER_HDR_EN
        first_byte  = HDR_BYTE;
        first_state = S_HDR;
`else
        first_byte  = sel_byte(rdata, 1'b0, LSBF);
        first_state = S_BYTE_A;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (in_valid && full) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        hold_q  <= rdata;
                        byte_q  <= first_byte;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= first_state;
                    end
                end
`ifdef FP16_SER_HDR_EN
                S_HDR: begin
                    if (out_ready) begin
                        byte_q  <= sel_byte(hold_q, 1'b0, LSBF);
                        state_q <= S_BYTE_A;
                    end
                end
`endif
                S_BYTE_A: begin
                    if (out_ready) begin
                        byte_q  <= sel_byte(hold_q, 1'b1, LSBF);
                        last_q  <= 1'b1;
                        state_q <= S_BYTE_B;
                    end
                end
                S_BYTE_B: begin
                    if (out_ready) begin
                        last_q <= 1'b0;
                        if (!empty) begin
                            hold_q  <= rdata;
                            byte_q  <= first_byte;
                            state_q <= first_state;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_result_serializer.sv
// Directed bench for fp16_result_serializer: vector table plus corner sequences.
// Define FP16_SER_HDR_EN for both bench and RTL to check the header variant.
module tb_fp16_result_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [15:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    fp16_result_serializer #(
        .DEPTH(4),
        .LSB_FIRST(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a valid byte, check it, then accept it
    task automatic recv(input logic [7:0] eb, input logic el,
                        input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            chk({name, " timeout"}, 32'(out_valid), 32'd1);
        end else begin
            chk({name, " byte"}, 32'(out_byte), 32'(eb));
            chk({name, " last"}, 32'(out_last), 32'(el));
            tick();
        end
    endtask

    task automatic recv_word(input logic [15:0] w, input string name);
`ifdef FP16_SER_HDR_EN
        recv(8'hA5, 1'b0, {name, " hdr"});
`endif
        recv(w[7:0], 1'b0, {name, " lo"});
        recv(w[15:8], 1'b1, {name, " hi"});
    endtask

    initial begin
        logic [7:0] exp_b [$];
        logic       exp_l [$];

        vecs[0] = '{16'h3C00, 8'h00, 8'h3C};
        vecs[1] = '{16'hC500, 8'h00, 8'hC5};
        vecs[2] = '{16'h7BFF, 8'hFF, 8'h7B};
        vecs[3] = '{16'hFC00, 8'h00, 8'hFC};
        vecs[4] = '{16'h0001, 8'h01, 8'h00};
        vecs[5] = '{16'h8000, 8'h00, 8'h80};

        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_byte", 32'(out_byte), 0);
        chk("rst out_last", 32'(out_last), 0);
        chk("rst fifo_count", 32'(fifo_count), 0);
        chk("rst overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();
        chk("rst in_ready", 32'(in_ready), 1);

        // Single words with out_ready high: latency, byte order, return to idle
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].data);
            chk("lat valid low", 32'(out_valid), 0);
            chk("lat count", 32'(fifo_count), 1);
            tick();
            chk("lat valid high", 32'(out_valid), 1);
`ifdef FP16_SER_HDR_EN
            recv(8'hA5, 1'b0, "vec hdr");
`endif
            recv(vecs[i].b0, 1'b0, "vec b0");
            recv(vecs[i].b1, 1'b1, "vec b1");
            chk("vec idle", 32'(out_valid), 0);
            chk("vec empty", 32'(fifo_count), 0);
        end

        // Backpressure holds the first data byte steady
        out_ready = 1'b0;
        push(16'hC500);
        tick();
`ifdef FP16_SER_HDR_EN
        recv(8'hA5, 1'b0, "bp hdr");
        out_ready = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 32'(out_valid), 1);
            chk("bp byte", 32'(out_byte), 32'h00);
            tick();
        end
        recv(8'h00, 1'b0, "bp b0");
        recv(8'hC5, 1'b1, "bp b1");
        chk("bp no dup", 32'(out_valid), 0);
        tick();
        chk("bp no dup2", 32'(out_valid), 0);

        // Fill to full, then overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(16'(i));
        end
        chk("fill count", 32'(fifo_count), 4);
        chk("fill in_ready", 32'(in_ready), 0);
        chk("fill ovf clear", 32'(overflow), 0);
        push(16'h0006);
        chk("ovf set", 32'(overflow), 1);
        chk("ovf count", 32'(fifo_count), 4);
        for (int i = 1; i <= 5; i++) begin
            recv_word(16'(i), "drain");
        end
        chk("drain idle", 32'(out_valid), 0);
        chk("ovf sticky", 32'(overflow), 1);

        // Back-to-back words stream without bubbles
        out_ready = 1'b0;
        push(16'h4142);
        push(16'h4344);
        push(16'h4546);
        tick();
        foreach (exp_b[i]) exp_b.delete();
        foreach (exp_l[i]) exp_l.delete();
        exp_b = {};
        exp_l = {};
`ifdef FP16_SER_HDR_EN
        exp_b = {8'hA5, 8'h42, 8'h41, 8'hA5, 8'h44, 8'h43, 8'hA5, 8'h46, 8'h45};
        exp_l = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_b = {8'h42, 8'h41, 8'h44, 8'h43, 8'h46, 8'h45};
        exp_l = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < exp_b.size(); i++) begin
            chk("b2b valid", 32'(out_valid), 1);
            chk("b2b byte", 32'(out_byte), 32'(exp_b[i]));
            chk("b2b last", 32'(out_last), 32'(exp_l[i]));
            tick();
        end
        chk("b2b idle", 32'(out_valid), 0);

        // Clear after the low byte is accepted: high byte never appears
        push(16'h1234);
`ifdef FP16_SER_HDR_EN
        recv(8'hA5, 1'b0, "clr hdr");
`endif
        recv(8'h34, 1'b0, "clr b0");
        out_ready = 1'b0;
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h5555;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr valid", 32'(out_valid), 0);
        chk("clr count", 32'(fifo_count), 0);
        chk("clr overflow", 32'(overflow), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("clr quiet", 32'(out_valid), 0);
            tick();
        end

        // Reset with words queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(16'h7700 + 16'(i));
        end
        chk("prerst count", 32'(fifo_count), 3);
        rst_n = 1'b0;
        tick();
        tick();
        chk("mrst valid", 32'(out_valid), 0);
        chk("mrst byte", 32'(out_byte), 0);
        chk("mrst last", 32'(out_last), 0);
        chk("mrst count", 32'(fifo_count), 0);
        chk("mrst overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();
        chk("mrst in_ready", 32'(in_ready), 1);
        push(16'hABCD);
        recv_word(16'hABCD, "post rst");
        chk("post rst idle", 32'(out_valid), 0);
        tick();
        chk("post rst idle2", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
